// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer: default widths, FSM states, shift modes.
// Optional rotate support is enabled with the SHIFT_SEQ_ROTATE_EN macro.
package shift_seq_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LOGICAL = 2'd0,
    ARITH   = 2'd1,
    ROTATE  = 2'd2
  } shmode_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the switch/key front end and the shift sequencer.
// The rot member is only honoured when SHIFT_SEQ_ROTATE_EN is defined.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic [CNT_W-1:0] shamt;
  logic             asr;
  logic             rot;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, shamt, asr, rot,
    input  q, busy, done
  );

  modport slave (
    input  start, load_val, shamt, asr, rot,
    output q, busy, done
  );

endinterface

// File: rtl/shift_sequencer_datapath.sv
// WIDTH-bit right-shift register with selectable fill bit; synchronous active-low reset.
// The rotate fill path exists only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq_datapath
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             Resetn,
  input  logic             i_load,
  input  logic             i_shift,
  input  shmode_t          i_mode,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic             w_fill;

  always_comb begin
    w_fill = 1'b0;
    case (i_mode)
      ARITH:   w_fill = r_q[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
      ROTATE:  w_fill = r_q[0];
`endif
      default: w_fill = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {w_fill, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Start-pulse driven sequencer: loads an operand, applies N single-bit right shifts, pulses done.
// Define SHIFT_SEQ_ROTATE_EN to honour the rot request; otherwise rot is ignored.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             Resetn,
  shift_sequencer_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  shmode_t          r_mode;
  shmode_t          w_mode_in;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_q;

  // Rotate takes priority over arithmetic when both are requested.
  always_comb begin
    w_mode_in = LOGICAL;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (bus.rot) begin
      w_mode_in = ROTATE;
    end else if (bus.asr) begin
      w_mode_in = ARITH;
    end
`else
    if (bus.asr) begin
      w_mode_in = ARITH;
    end
`endif
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_count == CNT_W'(1)) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_count <= '0;
      r_mode  <= LOGICAL;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_count <= bus.shamt;
        r_mode  <= w_mode_in;
      end else if (w_shift) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  shift_seq_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock      (clock),
    .Resetn     (Resetn),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_mode     (w_load ? w_mode_in : r_mode),
    .i_load_val (bus.load_val),
    .o_q        (w_q)
  );

  assign bus.q    = w_q;
  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, hand-written corner sequences, random ops.
// Expectations follow SHIFT_SEQ_ROTATE_EN when it is defined.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] ld;
    logic [3:0] n;
    bit         a;
    bit         r;
    logic [7:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        Resetn;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  vec_t        vt[9];

  shift_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clock  (clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: the result of N single-bit shifts, computed in one step.
  function automatic logic [7:0] model(input logic [7:0] v, input int unsigned n,
                                       input bit a, input bit r);
    logic [15:0]       d;
    logic signed [7:0] s;
    if (ROT_EN && r) begin
      d = {v, v} >> (n % 8);
      return d[7:0];
    end
    if (a) begin
      s = v;
      return s >>> n;
    end
    return v >> n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ld, input logic [3:0] n,
                        input bit a, input bit r, input logic [7:0] exp);
    int unsigned cyc = 0;
    bus.load_val = ld;
    bus.shamt    = n;
    bus.asr      = a;
    bus.rot      = r;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.load_val = 8'($urandom);
    bus.shamt    = 4'($urandom);
    bus.asr      = 1'($urandom);
    bus.rot      = 1'($urandom);
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " done seen"}, 32'(bus.done), 32'd1);
    check({tag, " latency"}, cyc, 32'(n));
    check({tag, " q"}, 32'(bus.q), 32'(exp));
    tick();
    check({tag, " done width"}, 32'(bus.done), 32'd0);
    check({tag, " busy after"}, 32'(bus.busy), 32'd0);
    check({tag, " q hold"}, 32'(bus.q), 32'(exp));
  endtask

  initial begin
    int unsigned cyc;
    logic [7:0]  rv;
    logic [3:0]  rn;
    bit          ra;
    bit          rr;

    vt[0] = '{8'h96, 4'd3,  1'b0, 1'b0, 8'h12};
    vt[1] = '{8'h96, 4'd3,  1'b1, 1'b0, 8'hF2};
    vt[2] = '{8'h96, 4'd0,  1'b0, 1'b0, 8'h96};
    vt[3] = '{8'h96, 4'd3,  1'b1, 1'b1, ROT_EN ? 8'hD2 : 8'hF2};
    vt[4] = '{8'h80, 4'd15, 1'b1, 1'b0, 8'hFF};
    vt[5] = '{8'h80, 4'd8,  1'b0, 1'b0, 8'h00};
    vt[6] = '{8'h7F, 4'd9,  1'b1, 1'b0, 8'h00};
    vt[7] = '{8'h01, 4'd1,  1'b0, 1'b1, ROT_EN ? 8'h80 : 8'h00};
    vt[8] = '{8'hA5, 4'd8,  1'b0, 1'b1, ROT_EN ? 8'hA5 : 8'h00};

    bus.start    = 1'b0;
    bus.load_val = 8'h5C;
    bus.shamt    = 4'd0;
    bus.asr      = 1'b0;
    bus.rot      = 1'b0;
    Resetn       = 1'b0;
    tick();
    tick();
    check("reset q", 32'(bus.q), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    Resetn = 1'b1;
    tick();
    check("idle hold q", 32'(bus.q), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].ld, vt[i].n, vt[i].a, vt[i].r, vt[i].exp);
    end

    // Arithmetic shift, stepping through every intermediate value.
    bus.load_val = 8'h96;
    bus.shamt    = 4'd3;
    bus.asr      = 1'b1;
    bus.rot      = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("asr load q", 32'(bus.q), 32'h96);
    check("asr busy", 32'(bus.busy), 32'd1);
    tick();
    check("asr step1", 32'(bus.q), 32'hCB);
    tick();
    check("asr step2", 32'(bus.q), 32'hE5);
    check("asr no done yet", 32'(bus.done), 32'd0);
    tick();
    check("asr step3", 32'(bus.q), 32'hF2);
    check("asr done", 32'(bus.done), 32'd1);
    tick();
    check("asr done cleared", 32'(bus.done), 32'd0);

    // Start re-pulsed while busy and held through the done cycle must be ignored.
    bus.load_val = 8'h96;
    bus.shamt    = 4'd5;
    bus.asr      = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start    = 1'b1;
    bus.load_val = 8'h00;
    bus.shamt    = 4'd1;
    bus.asr      = 1'b1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("busy-start done seen", 32'(bus.done), 32'd1);
    check("busy-start latency", cyc, 32'd4);
    check("busy-start q", 32'(bus.q), 32'h04);
    tick();
    check("start in done not queued busy", 32'(bus.busy), 32'd0);
    check("start in done not queued q", 32'(bus.q), 32'h04);
    bus.start = 1'b0;
    tick();
    check("idle after ignored start busy", 32'(bus.busy), 32'd0);
    check("idle after ignored start q", 32'(bus.q), 32'h04);

    // Reset in the middle of an operation aborts without a done pulse.
    bus.load_val = 8'hFF;
    bus.shamt    = 4'd6;
    bus.asr      = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("pre-abort q", 32'(bus.q), 32'h7F);
    Resetn = 1'b0;
    tick();
    check("abort q", 32'(bus.q), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    Resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post-abort done", 32'(bus.done), 32'd0);
      check("post-abort busy", 32'(bus.busy), 32'd0);
    end
    run_op("restart", 8'h5A, 4'd2, 1'b0, 1'b0, 8'h16);

    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom);
      rn = 4'($urandom_range(0, 15));
      ra = 1'($urandom);
      rr = 1'($urandom);
      run_op($sformatf("rand%0d", i), rv, rn, ra, rr, model(rv, 32'(rn), ra, rr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
